alu_seq: RTL and testbench

//  Registered, handshaked successor of the combinational 16-op ALU: width-parametrised datapath,

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_addsub.sv | 30 +++
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Package shared by the sequential ALU and its bench.
// Contents: function-select codes, handshake FSM state encoding, flag bit
// positions in the registered flag vector, and small op-classification helpers.
package alu_pkg;

  localparam logic [3:0] FS_SLL   = 4'h0;
  localparam logic [3:0] FS_SLA   = 4'h1;
  localparam logic [3:0] FS_SRL   = 4'h2;
  localparam logic [3:0] FS_SRA   = 4'h3;
  localparam logic [3:0] FS_ADD   = 4'h4;
  localparam logic [3:0] FS_ADC   = 4'h5;
  localparam logic [3:0] FS_SUB   = 4'h6;
  localparam logic [3:0] FS_ABS   = 4'h7;
  localparam logic [3:0] FS_MUL   = 4'h8;
  localparam logic [3:0] FS_ZERO  = 4'h9;
  localparam logic [3:0] FS_PASSA = 4'hA;
  localparam logic [3:0] FS_PASSB = 4'hB;
  localparam logic [3:0] FS_AND   = 4'hC;
  localparam logic [3:0] FS_OR    = 4'hD;
  localparam logic [3:0] FS_XOR   = 4'hE;
  localparam logic [3:0] FS_NOT   = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Bit positions inside the {N,C,V,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 3;

  // Ops whose carry result is remembered for later ADC chains.
  function automatic logic updates_cflag(input logic [3:0] fs);
    return (fs == FS_SLA) || (fs == FS_ADD) || (fs == FS_ADC) ||
           (fs == FS_SUB) || (fs == FS_ABS);
  endfunction

  // Logical ops report N=Z=0 regardless of the result.
  function automatic logic nz_suppressed(input logic [3:0] fs);
    return (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_AND) ||
           (fs == FS_OR)  || (fs == FS_XOR) || (fs == FS_NOT);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle of the sequential ALU.
// Input side : in_valid/in_ready, operands A/B, function select FS, cin, cin_sel.
// Output side: out_valid/out_ready, result Y, flags N/C/V/Z.
// master = producer of ops and consumer of results; slave = the ALU.
interface alu_seq_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   FS;
  logic         cin;
  logic         cin_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         N;
  logic         C;
  logic         V;
  logic         Z;

  modport master (
    output in_valid, A, B, FS, cin, cin_sel, out_ready,
    input  in_ready, out_valid, Y, N, C, V, Z
  );

  modport slave (
    input  in_valid, A, B, FS, cin, cin_sel, out_ready,
    output in_ready, out_valid, Y, N, C, V, Z
  );
endinterface

// File: rtl/alu_addsub.sv
// Combinational W-bit adder/subtractor.
// Ports: a, b operands; cin carry-in (ignored when sub=1); sub selects a+~b+1;
// y sum; cout carry out of bit W-1 (for sub, 1 means no borrow); ovf signed overflow.
module alu_addsub #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic signed [W-1:0] y,
  output logic                cout,
  output logic                ovf
);

  logic [W-1:0] b_eff;
  logic         cin_eff;
  logic [W:0]   sum;

  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : cin;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin_eff};
    y       = sum[W-1:0];
    cout    = sum[W];
    // Overflow: both addends share a sign that the sum does not.
    ovf     = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 16-op ALU with an iterative shift-add multiplier and a
// persistent carry flag for ADC chains.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (alu_seq_if.slave):
//   in_valid/in_ready accept A,B,FS,cin,cin_sel; out_valid/out_ready return Y,N,C,V,Z.
// Non-MUL ops complete on the transfer edge; MUL spends W cycles in ST_MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int MULW = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(W);

  state_t state_q, state_d;
  logic   xfer, load_alu, mul_start, mul_done;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  mcand_q, mplier_q, acc_q, acc_step;
  logic signed [MULW-1:0] a_lo, b_lo;

  logic signed [W-1:0] a_in, b_in, as_y;
  logic                as_cin, as_sub, as_cout, as_ovf;

  logic [W-1:0] res_y;
  logic         res_n, res_c, res_v, res_z;

  logic [W-1:0] y_p1;
  logic [3:0]   flags_p1;
  logic         vld_p1;
  logic         cflag_q;

  assign a_in = bus.A;
  assign b_in = bus.B;
  assign a_lo = bus.A[MULW-1:0];
  assign b_lo = bus.B[MULW-1:0];

  assign bus.in_ready  = (state_q == ST_IDLE) && (!vld_p1 || bus.out_ready);
  assign xfer          = bus.in_valid && bus.in_ready;

  assign as_sub = (bus.FS == FS_SUB) || (bus.FS == FS_ABS);
  assign as_cin = (bus.FS == FS_ADC) ? (bus.cin_sel ? cflag_q : bus.cin) : 1'b0;

  alu_addsub #(.W(W)) u_addsub (
    .a    (a_in),
    .b    (b_in),
    .cin  (as_cin),
    .sub  (as_sub),
    .y    (as_y),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Stage p0: single-cycle result and flags from the presented operands
  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.FS)
      FS_SLL, FS_SLA: res_y = {a_in[W-2:0], 1'b0};
      FS_SRL:         res_y = {1'b0, a_in[W-1:1]};
      FS_SRA:         res_y = {a_in[W-1], a_in[W-1:1]};
      FS_ADD, FS_ADC, FS_SUB: begin
        res_y = as_y;
        res_c = as_cout;
        res_v = as_ovf;
      end
      FS_ABS: begin
        // Negating min_int wraps back to min_int, which is the intended result.
        res_y = as_y[W-1] ? -as_y : as_y;
        res_c = as_cout;
        res_v = as_ovf;
      end
      FS_PASSA: res_y = a_in;
      FS_PASSB: res_y = b_in;
      FS_AND:   res_y = a_in & b_in;
      FS_OR:    res_y = a_in | b_in;
      FS_XOR:   res_y = a_in ^ b_in;
      FS_NOT:   res_y = ~a_in;
      default:  res_y = '0;
    endcase
    if (bus.FS == FS_SLA) begin
      res_c = a_in[W-1];
      res_v = a_in[W-1] ^ a_in[W-2];
    end
    res_n = nz_suppressed(bus.FS) ? 1'b0 : res_y[W-1];
    res_z = nz_suppressed(bus.FS) ? 1'b0 : (res_y == '0);
  end

  // Shift-add on sign-extended operands; the W-bit accumulator keeps the
  // product mod 2^W, which equals the truncated signed product.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (bus.FS == FS_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CW'(W-1)) begin
          state_d  = ST_IDLE;
          mul_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: control, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      flags_p1 <= '0;
      cflag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        cnt_q <= '0;
      end else if (state_q == ST_MUL) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_alu || mul_done) begin
        vld_p1 <= 1'b1;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (load_alu) begin
        y_p1             <= res_y;
        flags_p1[FLAG_N] <= res_n;
        flags_p1[FLAG_C] <= res_c;
        flags_p1[FLAG_V] <= res_v;
        flags_p1[FLAG_Z] <= res_z;
        if (updates_cflag(bus.FS)) begin
          cflag_q <= res_c;
        end
      end else if (mul_done) begin
        y_p1             <= acc_step;
        flags_p1[FLAG_N] <= acc_step[W-1];
        flags_p1[FLAG_C] <= 1'b0;
        flags_p1[FLAG_V] <= 1'b0;
        flags_p1[FLAG_Z] <= (acc_step == '0);
      end
    end
  end

  // Multiplier datapath registers
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand_q  <= W'(a_lo);
      mplier_q <= W'(b_lo);
      acc_q    <= '0;
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= {mcand_q[W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.Y         = y_p1;
  assign bus.N         = flags_p1[FLAG_N];
  assign bus.C         = flags_p1[FLAG_C];
  assign bus.V         = flags_p1[FLAG_V];
  assign bus.Z         = flags_p1[FLAG_Z];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=32, MULW=16) with an expected-result queue.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int MULW = 16;

  typedef struct packed {
    logic [31:0] y;
    logic        n;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W), .MULW(MULW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  logic model_cf;
  int   n_vec;
  int   n_err;

  function automatic exp_t model(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sel);
    exp_t        e;
    longint      sa, sbv, r;
    logic [32:0] s;
    logic [31:0] d;
    logic        cc;
    bit          nzoff;
    e     = '0;
    nzoff = 1'b0;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    case (fs)
      FS_SLL: begin e.y = a << 1; nzoff = 1'b1; end
      FS_SLA: begin e.y = a << 1; e.c = a[31]; e.v = a[31] ^ a[30]; end
      FS_SRL: begin e.y = a >> 1; nzoff = 1'b1; end
      FS_SRA: e.y = $signed(a) >>> 1;
      FS_ADD, FS_ADC: begin
        cc  = (fs == FS_ADC) ? (sel ? model_cf : ci) : 1'b0;
        s   = 33'(a) + 33'(b) + 33'(cc);
        e.y = s[31:0];
        e.c = s[32];
        r   = sa + sbv + longint'(cc);
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      FS_SUB, FS_ABS: begin
        r   = sa - sbv;
        d   = r[31:0];
        e.c = (a >= b);
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.y = (fs == FS_ABS && d[31]) ? -d : d;
      end
      FS_MUL: begin
        r   = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
        e.y = r[31:0];
      end
      FS_ZERO:  e.y = '0;
      FS_PASSA: e.y = a;
      FS_PASSB: e.y = b;
      FS_AND:   begin e.y = a & b; nzoff = 1'b1; end
      FS_OR:    begin e.y = a | b; nzoff = 1'b1; end
      FS_XOR:   begin e.y = a ^ b; nzoff = 1'b1; end
      default:  begin e.y = ~a;    nzoff = 1'b1; end
    endcase
    e.n = nzoff ? 1'b0 : e.y[31];
    e.z = nzoff ? 1'b0 : (e.y == 32'h0);
    if (fs == FS_SLA || fs == FS_ADD || fs == FS_ADC || fs == FS_SUB || fs == FS_ABS)
      model_cf = e.c;
    return e;
  endfunction

  // Present one op, queue its expected result, and complete the transfer.
  task automatic issue(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sel);
    int k;
    bus.FS = fs; bus.A = a; bus.B = b; bus.cin = ci; bus.cin_sel = sel;
    bus.in_valid = 1'b1;
    sb.push_back(model(fs, a, b, ci, sel));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 200);
    if (k >= 200) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout fs=%0d in_ready stayed %b want 1", fs, bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and capture the output at a falling edge.
  task automatic collect(output logic [31:0] y, output logic [3:0] f, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 200);
    y = bus.Y;
    f = {bus.N, bus.C, bus.V, bus.Z};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.Y !== 32'h0) begin n_err++; $display("FAIL reset_y got %h want 0", bus.Y); end
    n_vec++;
    if ({bus.N, bus.C, bus.V, bus.Z} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {bus.N, bus.C, bus.V, bus.Z});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    model_cf = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] y; logic [3:0] f; int cyc; exp_t e;
    issue(FS_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    collect(y, f, cyc);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 1) begin n_err++; $display("FAIL add_latency got %0d want 1", cyc); end
    n_vec++;
    if ({y, f} !== e) begin n_err++; $display("FAIL add_model got %h want %h", {y, f}, e); end
    n_vec++;
    if ({y, f} !== {32'h8000_0000, 4'b1010}) begin
      n_err++; $display("FAIL add_const got %h want %h", {y, f}, {32'h8000_0000, 4'b1010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_adc();
    logic [31:0] y; logic [3:0] f; int cyc; exp_t e;
    issue(FS_SUB, 32'd5, 32'd5, 1'b0, 1'b0);
    collect(y, f, cyc);
    e = sb.pop_front();
    n_vec++;
    if ({y, f} !== {32'h0, 4'b0101} || {y, f} !== e) begin
      n_err++; $display("FAIL sub_zero got %h want %h", {y, f}, {32'h0, 4'b0101});
    end
    @(posedge clk); #1;
    issue(FS_ADC, 32'd1, 32'd1, 1'b0, 1'b1);
    collect(y, f, cyc);
    e = sb.pop_front();
    n_vec++;
    if ({y, f} !== {32'h3, 4'b0000} || {y, f} !== e) begin
      n_err++; $display("FAIL adc_cflag got %h want %h", {y, f}, {32'h3, 4'b0000});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] y; logic [3:0] f; int cyc; exp_t e; bit ir_bad;
    logic [31:0] ma [4] = '{32'h0000_FFFF, 32'h0000_8000, 32'hABCD_7FFF, 32'h0000_1234};
    logic [31:0] mb [4] = '{32'h0000_0003, 32'h0000_8000, 32'h1234_8001, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(FS_MUL, ma[i], mb[i], 1'b0, 1'b0);
      cyc = 0;
      ir_bad = 1'b0;
      do begin
        @(negedge clk);
        cyc++;
        if (!bus.out_valid && bus.in_ready) ir_bad = 1'b1;
      end while (!bus.out_valid && cyc < 200);
      y = bus.Y;
      f = {bus.N, bus.C, bus.V, bus.Z};
      e = sb.pop_front();
      n_vec++;
      if (ir_bad) begin n_err++; $display("FAIL mul_in_ready%0d got 1 during MUL want 0", i); end
      n_vec++;
      if (cyc < W || cyc > W + 1) begin n_err++; $display("FAIL mul_latency%0d got %0d want %0d..%0d", i, cyc, W, W + 1); end
      n_vec++;
      if ({y, f} !== e) begin n_err++; $display("FAIL mul_result%0d got %h want %h", i, {y, f}, e); end
      if (i == 0) begin
        n_vec++;
        if ({y, f} !== {32'hFFFF_FFFD, 4'b1000}) begin
          n_err++; $display("FAIL mul_const got %h want %h", {y, f}, {32'hFFFF_FFFD, 4'b1000});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y; logic [3:0] f; int cyc; exp_t e;
    bus.out_ready = 1'b0;
    issue(FS_AND, 32'hF0F0_FFFF, 32'h0FF0_0FF0, 1'b0, 1'b0);
    collect(y, f, cyc);
    bus.FS = FS_OR; bus.A = 32'h1200_0034; bus.B = 32'h0056_7800;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.Y} !== {1'b1, 1'b0, y}) begin
        n_err++;
        $display("FAIL hold%0d got ov=%b ir=%b y=%h want ov=1 ir=0 y=%h", i, bus.out_valid, bus.in_ready, bus.Y, y);
      end
    end
    sb.push_back(model(FS_OR, 32'h1200_0034, 32'h0056_7800, 1'b0, 1'b0));
    bus.out_ready = 1'b1;
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.in_ready, bus.Y, bus.N, bus.C, bus.V, bus.Z} !== {1'b1, e}) begin
      n_err++; $display("FAIL hold_release got ir=%b y=%h want ir=1 %h", bus.in_ready, bus.Y, e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if ({bus.out_valid, bus.Y, bus.N, bus.C, bus.V, bus.Z} !== {1'b1, e}) begin
      n_err++; $display("FAIL after_hold got ov=%b y=%h want ov=1 %h", bus.out_valid, bus.Y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    localparam int NF = 18;
    localparam int NR = 24;
    logic [3:0]  tf [NF] = '{FS_SLL, FS_SLA, FS_SRL, FS_SRA, FS_ADD, FS_ADC, FS_SUB, FS_ABS, FS_ZERO,
                             FS_PASSA, FS_PASSB, FS_AND, FS_OR, FS_XOR, FS_NOT, FS_ABS, FS_SLA, FS_ADC};
    logic [31:0] ta [NF] = '{32'h8000_0001, 32'h4000_0000, 32'h8000_0003, 32'h8000_0002, 32'hFFFF_FFFF,
                             32'h0000_0010, 32'h0000_0003, 32'h8000_0000, 32'h1234_5678, 32'h8765_4321,
                             32'h0, 32'hFF00_FF00, 32'h0F0F_0000, 32'hAAAA_5555, 32'h0000_FFFF,
                             32'h0000_0002, 32'hC000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [NF] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0001,
                             32'h0000_0020, 32'h0000_0007, 32'h0000_0000, 32'h1, 32'h2,
                             32'hDEAD_BEEF, 32'h0FF0_0FF0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h0,
                             32'h0000_0009, 32'h0, 32'h0000_0000};
    logic [1:0]  tc [NF] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [3:0] fs; logic [31:0] a, b; logic ci, sel;
    exp_t e;
    for (int i = 0; i < NF + NR; i++) begin
      if (i < NF) begin
        fs = tf[i]; a = ta[i]; b = tb[i]; ci = tc[i][1]; sel = tc[i][0];
      end else begin
        fs = 4'($urandom_range(0, 15));
        if (fs == FS_MUL) fs = FS_XOR;
        a = $urandom; b = $urandom; ci = 1'($urandom); sel = 1'($urandom);
      end
      bus.FS = fs; bus.A = a; bus.B = b; bus.cin = ci; bus.cin_sel = sel;
      bus.in_valid = 1'b1;
      sb.push_back(model(fs, a, b, ci, sel));
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %b want 1", i, bus.in_ready); end
      if (i > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({bus.out_valid, bus.Y, bus.N, bus.C, bus.V, bus.Z} !== {1'b1, e}) begin
          n_err++; $display("FAIL b2b%0d got ov=%b %h want ov=1 %h", i - 1, bus.out_valid,
                            {bus.Y, bus.N, bus.C, bus.V, bus.Z}, e);
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if ({bus.out_valid, bus.Y, bus.N, bus.C, bus.V, bus.Z} !== {1'b1, e}) begin
      n_err++; $display("FAIL b2b_last got ov=%b %h want ov=1 %h", bus.out_valid,
                        {bus.Y, bus.N, bus.C, bus.V, bus.Z}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_mul();
    logic [31:0] y; logic [3:0] f; int cyc; exp_t e; bit seen_ov;
    issue(FS_SUB, 32'd9, 32'd9, 1'b0, 1'b0);
    collect(y, f, cyc);
    e = sb.pop_front();
    n_vec++;
    if ({y, f} !== e) begin n_err++; $display("FAIL pre_rst_sub got %h want %h", {y, f}, e); end
    @(posedge clk); #1;
    issue(FS_MUL, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    model_cf = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov = 1'b1;
    end
    n_vec++;
    if (seen_ov) begin n_err++; $display("FAIL rst_mul_out_valid got 1 want 0"); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mul_idle got in_ready=%b want 1", bus.in_ready); end
    @(posedge clk); #1;
    issue(FS_ADC, 32'd0, 32'd0, 1'b0, 1'b1);
    collect(y, f, cyc);
    e = sb.pop_front();
    n_vec++;
    if ({y, f} !== {32'h0, 4'b0001} || {y, f} !== e) begin
      n_err++; $display("FAIL rst_cflag got %h want %h", {y, f}, {32'h0, 4'b0001});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_cf = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.FS = FS_SLL;
    bus.cin = 1'b0; bus.cin_sel = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_adc();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_rst_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
